// File: rtl/pipeline_hazard_ctrl_n.sv
// pipeline_hazard_ctrl_n: N-stage stall/flush chaining, load-use scoreboard and held branch redirect.
// Define PIPELINE_PERF_EN to add saturating stall/bubble/redirect counters (tied to 0 otherwise).
module pipeline_hazard_ctrl_n #(
  parameter int NUM_STAGES   = 5,
  parameter int DEC_STAGE    = 1,
  parameter int EXEC_STAGE   = 2,
  parameter int NUM_SRC      = 2,
  parameter int PREG_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          external_done,
  input  logic                          done,
  input  logic                          fetch_done,
  input  logic [NUM_STAGES-1:0]         stage_busy,
  input  logic [NUM_SRC-1:0]            dec_src_enable,
  input  logic [NUM_SRC*PREG_WIDTH-1:0] dec_src_addr,
  input  logic                          exec_wb_reg,
  input  logic                          exec_mem_load,
  input  logic [PREG_WIDTH-1:0]         exec_dst_addr,
  input  logic                          exec_take_branch,
  input  logic [ADDR_WIDTH-1:0]         exec_branch_target,
  output logic [NUM_STAGES-1:0]         stage_stall,
  output logic [NUM_STAGES-1:0]         stage_flush,
  output logic                          fetch_branch,
  output logic [ADDR_WIDTH-1:0]         fetch_branch_target,
  output logic [CNT_WIDTH-1:0]          perf_stall_cycles,
  output logic [CNT_WIDTH-1:0]          perf_bubbles,
  output logic [CNT_WIDTH-1:0]          perf_redirects
);
  logic run, hazard, pending, discard, unused;
  logic [ADDR_WIDTH-1:0] pend_target;
  logic [NUM_STAGES-1:0] loc, stall_c, flush_c;
  logic [NUM_SRC-1:0] exec_hit, sb_hit;
  assign run = external_done & ~done;
  assign unused = &{1'b0, stage_busy[0]};
  always_comb begin
    exec_hit = '0;
    for (int k = 0; k < NUM_SRC; k++)
      exec_hit[k] = dec_src_enable[k] & exec_wb_reg & exec_mem_load &
                    (exec_dst_addr == dec_src_addr[k*PREG_WIDTH +: PREG_WIDTH]);
  end
  // Loads that already left EXEC but whose data is not yet forwardable.
  if (LOAD_LATENCY > 1) begin : g_sb
    localparam int D = LOAD_LATENCY - 1;
    logic [D:1] valid;
    logic [PREG_WIDTH-1:0] addr [1:D];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        valid <= '0;
        for (int s = 1; s <= D; s++) addr[s] <= '0;
      end else if (!stage_stall[EXEC_STAGE]) begin
        valid[1] <= exec_wb_reg & exec_mem_load & ~stage_flush[EXEC_STAGE];
        addr[1] <= exec_dst_addr;
        for (int s = 2; s <= D; s++) begin
          valid[s] <= valid[s-1];
          addr[s] <= addr[s-1];
        end
      end
    always_comb begin
      sb_hit = '0;
      for (int k = 0; k < NUM_SRC; k++)
        for (int s = 1; s <= D; s++)
          if (dec_src_enable[k] && valid[s] && addr[s] == dec_src_addr[k*PREG_WIDTH +: PREG_WIDTH])
            sb_hit[k] = 1'b1;
    end
  end else begin : g_nosb
    assign sb_hit = '0;
  end
  // A taken branch squashes decode, so its hazard must not stall anything.
  assign hazard = |(exec_hit | sb_hit) & ~exec_take_branch;
  always_comb begin
    loc = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      loc[i] = (i == 0) ? ~fetch_done : stage_busy[i] | (i == DEC_STAGE && hazard);
    stall_c = '0;
    stall_c[NUM_STAGES-1] = loc[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) stall_c[i] = loc[i] | stall_c[i+1];
    flush_c = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      flush_c[i] = (i == 0) ? ~fetch_done | exec_take_branch | discard
                            : loc[i] | (i <= DEC_STAGE && exec_take_branch);
  end
  assign stage_stall = run ? stall_c : '1;
  assign stage_flush = run ? flush_c : '1;
  assign fetch_branch = exec_take_branch | pending;
  assign fetch_branch_target = exec_take_branch ? exec_branch_target : pend_target;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= 1'b0;
      pend_target <= '0;
      discard <= 1'b0;
    end else if (run) begin
      if (exec_take_branch && stage_stall[0]) begin
        pending <= 1'b1;
        pend_target <= exec_branch_target;
      end else if (pending && !stage_stall[0] && !exec_take_branch) pending <= 1'b0;
      if (exec_take_branch && !fetch_done) discard <= 1'b1;
      else if (discard && fetch_done) discard <= 1'b0;
    end
`ifdef PIPELINE_PERF_EN
  localparam logic [CNT_WIDTH-1:0] ONE = 1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_bubbles <= '0;
      perf_redirects <= '0;
    end else if (run) begin
      if (stage_stall[DEC_STAGE] && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + ONE;
      if (hazard && !(&perf_bubbles)) perf_bubbles <= perf_bubbles + ONE;
      if (exec_take_branch && !stage_stall[EXEC_STAGE] && !(&perf_redirects)) perf_redirects <= perf_redirects + ONE;
    end
`else
  assign perf_stall_cycles = '0;
  assign perf_bubbles = '0;
  assign perf_redirects = '0;
`endif
endmodule
